id_ex_stage_buf: RTL
====================

Name: id_ex_stage_buf

Overview:
Parametrised ID->EX pipeline stage buffer: the successor of the fixed-field ID/EX register. It carries a packed data payload and a packed control payload with valid/ready handshaking, synchronous flush for branch/jump squash, and bubble gating so that an empty stage never asserts control. It also keeps saturating stall and bubble counters for performance debug. It sits between the decode/register-read stage and the ALU stage.

Parameters:
DATA_W, 168, data payload width (PC+4, RD1, RD2, Imm, PC, rd, DMType packed by the instantiating stage)
CTRL_W, 14, control payload width (RegWrite, MemWrite, MemRead, WDSel, ALUSrc, ALUOp, NPCOp)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of every beat held in the stage
s_valid  in  1  ID side: beat offered
s_ready  out  1  ID side: stage can accept
s_data  in  DATA_W  ID side: data payload
s_ctrl  in  CTRL_W  ID side: control payload
m_valid  out  1  EX side: beat present
m_ready  in  1  EX side: consumer accepts
m_data  out  DATA_W  EX side: data payload
m_ctrl  out  CTRL_W  EX side: control payload, all zeros when m_valid=0
stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready=0
bubble_cnt  out  CNT_W  cycles with m_valid=0

Behaviour:
- Accept: s_valid && s_ready at the rising edge. Deliver: m_valid && m_ready at the rising edge. Beat order is preserved. No beat is duplicated or lost except by flush.
- Latency: an accepted beat appears on m_* in the cycle after acceptance. Sustained throughput is 1 beat/cycle while m_ready=1.
- Main register: holds m_valid_q, data, ctrl. It loads when it is empty or its beat is being delivered.
- Bubble gating: m_ctrl = m_valid ? ctrl_q : 0. m_data holds its last value when invalid.
- Data rule: payload is passed bit-exact with no arithmetic. Data/ctrl registers load only on accept, to save power.
- Flush: has the highest priority. The next state has every entry invalid, including any skid entry. A beat accepted in the flush cycle is discarded. A beat delivered in the flush cycle counts as delivered. Data registers are not cleared.
- Reset (asserted at any time, including mid-transfer): m_valid=0, m_data=0, m_ctrl=0, skid entry invalid, s_ready=1, stall_cnt=0, bubble_cnt=0. The stage leaves reset on the first rising edge after reset is released.
- Counters: each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 with no wrap. Counters are not cleared by flush.
- Holding EX: while m_valid=1 and m_ready=0, m_data and m_ctrl are stable.

Optional Feature:
SKID_BUFFER_EN
- Defined: a 2-entry buffer made of the main register plus one skid register. s_ready is a flop equal to "skid empty", with no combinational path from m_ready. If the main register is full, m_ready=0, and a beat is accepted, that beat goes to the skid register. When the main beat is delivered, the skid entry moves to the main register in the same edge, and the new input may be accepted into the skid. Once both entries are full, s_ready=0 on the next cycle.
- Undefined: single entry. s_ready = !m_valid || m_ready (combinational). The skid register is not built.

Test Plan:
- Reset: hold reset=0 mid-stream with m_valid=1 -> m_valid=0, m_ctrl=0, m_data=0, s_ready=1, both counters 0. Release reset, send s_data=0xA5, s_ctrl=0x3FFF -> the next cycle shows m_valid=1 with the same values.
- Streaming: 8 beats with data 1..8, s_valid=1 and m_ready=1 throughout -> m_data=1..8 on consecutive cycles starting 1 cycle after the first accept; stall_cnt=0.
- Backpressure: m_ready=0 for 5 cycles with a beat (data=0x55) held -> m_data stays 0x55 and stall_cnt=5. Without the macro s_ready=0 for those 5 cycles. With the macro, one extra beat (0x66) is accepted and s_ready then drops. Releasing m_ready delivers 0x55 then 0x66 in order.
- Flush with accept: flush=1 while s_valid=1, s_ready=1, and the stage holds 1 or 2 beats -> next cycle m_valid=0, m_ctrl=0, and the flushed beats never appear on m_*.
- Bubble gating: s_valid=0 for 3 cycles with s_ctrl=0x3FFF on the bus -> m_ctrl=0 and bubble_cnt increments by 3.
- Saturation: CNT_W=4, m_ready=0 for 20 cycles with m_valid=1 -> stall_cnt reaches 15 and holds 15.

Source files
------------

// File: rtl/id_ex_stage_buf.sv
// ID->EX pipeline stage buffer: packed data/control payload with valid/ready
// handshake, synchronous flush, bubble gating of control and saturating
// stall/bubble performance counters.
// Build option: define SKID_BUFFER_EN for a two-entry stage (main + skid
// register) with a registered s_ready; otherwise a single entry is built and
// s_ready is combinational from m_ready.
module id_ex_stage_buf #(
  parameter int DATA_W = 168,
  parameter int CTRL_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CTRL_W-1:0] s_ctrl,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              accept;
  logic              deliver;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              main_load;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

`ifdef SKID_BUFFER_EN
  logic              sk_valid_q, sk_valid_d;
  logic [DATA_W-1:0] sk_data_q;
  logic [CTRL_W-1:0] sk_ctrl_q;
  logic              skid_load;
  logic              s_ready_q;

  assign s_ready = s_ready_q;

  // Two-entry next state: skid refills main on delivery, overflow goes to skid.
  always_comb begin
    accept     = s_valid && s_ready_q;
    deliver    = m_valid_q && m_ready;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    m_data_d   = s_data;
    m_ctrl_d   = s_ctrl;
    m_valid_d  = m_valid_q && !deliver;
    sk_valid_d = sk_valid_q && !deliver;
    if (deliver && sk_valid_q) begin
      main_load = 1'b1;
      m_data_d  = sk_data_q;
      m_ctrl_d  = sk_ctrl_q;
      m_valid_d = 1'b1;
    end else if (accept && (!m_valid_q || deliver)) begin
      main_load = 1'b1;
      m_valid_d = 1'b1;
    end
    if (accept && m_valid_q && (!deliver || sk_valid_q)) begin
      skid_load  = 1'b1;
      sk_valid_d = 1'b1;
    end
    if (flush) begin
      main_load  = 1'b0;
      skid_load  = 1'b0;
      m_valid_d  = 1'b0;
      sk_valid_d = 1'b0;
    end
  end

  // Skid entry; s_ready is registered as "skid will be empty".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_ctrl_q  <= '0;
      s_ready_q  <= 1'b1;
    end else begin
      sk_valid_q <= sk_valid_d;
      s_ready_q  <= !sk_valid_d;
      if (skid_load) begin
        sk_data_q <= s_data;
        sk_ctrl_q <= s_ctrl;
      end
    end
  end
`else
  assign s_ready = !m_valid_q || m_ready;

  // Single-entry next state; a beat accepted during flush is dropped.
  always_comb begin
    accept    = s_valid && s_ready;
    deliver   = m_valid_q && m_ready;
    main_load = accept && !flush;
    m_data_d  = s_data;
    m_ctrl_d  = s_ctrl;
    m_valid_d = m_valid_q && !deliver;
    if (accept) m_valid_d = 1'b1;
    if (flush)  m_valid_d = 1'b0;
  end
`endif

  // Main register; payload only moves when a beat actually lands here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      if (main_load) begin
        m_data_q <= m_data_d;
        m_ctrl_q <= m_ctrl_d;
      end
    end
  end

  // Saturating counter increments.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (m_valid_q && !m_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (!m_valid_q && (bubble_q != '1)) bubble_d = bubble_q + CNT_W'(1);
  end

  // Performance counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_ctrl     = m_valid_q ? m_ctrl_q : '0;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule
